// File: rtl/dm_responder.sv
// dm_responder: memory end of the dm_* processor data-memory interface.
// - Registered 1-cycle processor reads and posedge processor writes.
// - Self-clearing sweep after reset; init_done marks the end of the sweep.
// - Host req/ack port for preload and dump; the processor always wins arbitration.
// - Optional macro DM_WR_FWD_EN: when defined, a simultaneous dm_rd & dm_wr returns
//   dm_w_data (write-through). When undefined, it returns the old contents (read-first).
module dm_responder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic                  dm_rd,
    input  logic                  dm_wr,
    input  logic [DATA_WIDTH-1:0] dm_w_data,
    output logic [DATA_WIDTH-1:0] dm_r_data,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_ack,
    output logic                  init_done,
    output logic                  err_conflict,
    output logic                  err_oob
);

    // Index width of the implemented array. It also sizes the clear counter.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DM_WR_FWD_EN
    localparam bit WR_FWD = 1'b1;
`else
    localparam bit WR_FWD = 1'b0;
`endif

    typedef enum logic {
        S_INIT,
        S_RUN
    } main_state_e;

    typedef enum logic {
        H_IDLE,
        H_ACK
    } host_state_e;

    // Storage array. It is deliberately not reset; the INIT sweep clears it.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    main_state_e           main_state_q, main_state_d;
    host_state_e           host_state_q, host_state_d;
    logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] dm_r_data_q, dm_r_data_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  host_ack_q, host_ack_d;
    logic                  init_done_q, init_done_d;
    logic                  err_conflict_q, err_conflict_d;
    logic                  err_oob_q, err_oob_d;

    // Single memory write port, shared by the clear sweep, the processor and the host.
    logic                  mem_we_c;
    logic [IDX_W-1:0]      mem_waddr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    logic                  dm_in_range_c;
    logic                  host_in_range_c;
    logic [IDX_W-1:0]      dm_idx_c;
    logic [IDX_W-1:0]      host_idx_c;
    logic                  host_start_c;

    // Address decode: range test against DEPTH and index into the array.
    always_comb begin
        dm_in_range_c   = (32'(dm_addr) < DEPTH);
        host_in_range_c = (32'(host_addr) < DEPTH);
        dm_idx_c        = dm_addr[IDX_W-1:0];
        host_idx_c      = host_addr[IDX_W-1:0];
    end

    // Next-state logic for the main FSM, host FSM, read data, error flags and write port.
    always_comb begin
        main_state_d   = main_state_q;
        host_state_d   = H_IDLE;
        clr_cnt_d      = clr_cnt_q;
        dm_r_data_d    = dm_r_data_q;
        host_rdata_d   = host_rdata_q;
        host_ack_d     = 1'b0;
        init_done_d    = init_done_q;
        err_conflict_d = err_conflict_q;
        err_oob_d      = err_oob_q;
        mem_we_c       = 1'b0;
        mem_waddr_c    = '0;
        mem_wdata_c    = '0;
        host_start_c   = 1'b0;

        case (main_state_q)
            S_INIT: begin
                // Clear one word per cycle. All external requests are ignored.
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_cnt_q;
                mem_wdata_c = '0;
                dm_r_data_d = '0;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    main_state_d = S_RUN;
                    init_done_d  = 1'b1;
                    clr_cnt_d    = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end

            S_RUN: begin
                // Processor read. The array is sampled before the write lands (read-first).
                if (dm_rd) begin
                    if (!dm_in_range_c) begin
                        dm_r_data_d = '0;
                    end else if (dm_wr && WR_FWD) begin
                        dm_r_data_d = dm_w_data;
                    end else begin
                        dm_r_data_d = mem_q[dm_idx_c];
                    end
                end

                if (dm_rd && dm_wr) begin
                    err_conflict_d = 1'b1;
                end

                if ((dm_rd || dm_wr) && !dm_in_range_c) begin
                    err_oob_d = 1'b1;
                end

                // Processor write. Out-of-range writes are dropped.
                if (dm_wr && dm_in_range_c) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = dm_idx_c;
                    mem_wdata_c = dm_w_data;
                end

                // The host is served only on cycles with no processor access.
                host_start_c = init_done_q && host_req && !dm_rd && !dm_wr
                               && (host_state_q == H_IDLE);

                if (host_start_c) begin
                    host_state_d = H_ACK;
                    host_ack_d   = 1'b1;
                    if (!host_in_range_c) begin
                        err_oob_d = 1'b1;
                    end
                    if (host_we) begin
                        if (host_in_range_c) begin
                            mem_we_c    = 1'b1;
                            mem_waddr_c = host_idx_c;
                            mem_wdata_c = host_wdata;
                        end
                    end else begin
                        host_rdata_d = host_in_range_c ? mem_q[host_idx_c] : '0;
                    end
                end
            end

            default: begin
                main_state_d = S_INIT;
                clr_cnt_d    = '0;
            end
        endcase
    end

    // State and output registers. Reset abandons any activity and restarts the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_state_q   <= S_INIT;
            host_state_q   <= H_IDLE;
            clr_cnt_q      <= '0;
            dm_r_data_q    <= '0;
            host_rdata_q   <= '0;
            host_ack_q     <= 1'b0;
            init_done_q    <= 1'b0;
            err_conflict_q <= 1'b0;
            err_oob_q      <= 1'b0;
        end else begin
            main_state_q   <= main_state_d;
            host_state_q   <= host_state_d;
            clr_cnt_q      <= clr_cnt_d;
            dm_r_data_q    <= dm_r_data_d;
            host_rdata_q   <= host_rdata_d;
            host_ack_q     <= host_ack_d;
            init_done_q    <= init_done_d;
            err_conflict_q <= err_conflict_d;
            err_oob_q      <= err_oob_d;
        end
    end

    // Memory array write port.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign dm_r_data    = dm_r_data_q;
    assign host_rdata   = host_rdata_q;
    assign host_ack     = host_ack_q;
    assign init_done    = init_done_q;
    assign err_conflict = err_conflict_q;
    assign err_oob      = err_oob_q;

endmodule

// File: tb/tb_dm_responder.sv
// Testbench for dm_responder: scoreboard checking of processor and host reads,
// plus a second instance with DEPTH = 200 for out-of-range and reset-restart cases.
module tb_dm_responder;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

`ifdef DM_WR_FWD_EN
    localparam logic [DW-1:0] CONFLICT_EXP = 16'h2222;
`else
    localparam logic [DW-1:0] CONFLICT_EXP = 16'h1111;
`endif

    typedef struct {
        logic          is_wr;
        logic [DW-1:0] data;
    } host_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1 (DEPTH = 256)
    logic          rst, dm_rd, dm_wr, host_req, host_we;
    logic [AW-1:0] dm_addr, host_addr;
    logic [DW-1:0] dm_w_data, host_wdata, dm_r_data, host_rdata;
    logic          host_ack, init_done, err_conflict, err_oob;

    // Instance 2 (DEPTH = 200)
    logic          rst2, dm_rd2, dm_wr2, host_req2, host_we2;
    logic [AW-1:0] dm_addr2, host_addr2;
    logic [DW-1:0] dm_w_data2, host_wdata2, dm_r_data2, host_rdata2;
    logic          host_ack2, init_done2, err_conflict2, err_oob2;

    dm_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256)) u_dut (
        .clk(clk), .rst(rst),
        .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_w_data(dm_w_data),
        .dm_r_data(dm_r_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .init_done(init_done), .err_conflict(err_conflict), .err_oob(err_oob)
    );

    dm_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(200)) u_dut2 (
        .clk(clk), .rst(rst2),
        .dm_addr(dm_addr2), .dm_rd(dm_rd2), .dm_wr(dm_wr2), .dm_w_data(dm_w_data2),
        .dm_r_data(dm_r_data2),
        .host_req(host_req2), .host_we(host_we2), .host_addr(host_addr2),
        .host_wdata(host_wdata2), .host_rdata(host_rdata2), .host_ack(host_ack2),
        .init_done(init_done2), .err_conflict(err_conflict2), .err_oob(err_oob2)
    );

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    logic rd_seen = 1'b0;

    logic [DW-1:0] dm_q[$];
    host_exp_t     host_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: marks edges that sampled a processor read.
    always @(posedge clk) rd_seen <= dm_rd;

    // Monitor: pops the scoreboard when the DUT presents read data or a host ack.
    always @(negedge clk) begin
        if (rd_seen) begin
            if (dm_q.size() == 0) begin
                check("dm_unexpected_read", 32'(dm_r_data), 32'hDEAD_BEEF);
            end else begin
                check("dm_r_data", 32'(dm_r_data), 32'(dm_q.pop_front()));
            end
        end
        if (host_ack) begin
            host_exp_t e;
            ack_cnt++;
            if (host_q.size() == 0) begin
                check("host_unexpected_ack", 32'(host_ack), 32'h0);
            end else begin
                e = host_q.pop_front();
                if (!e.is_wr) check("host_rdata", 32'(host_rdata), 32'(e.data));
            end
        end
    end

    // Stimulus helpers for instance 1: each starts and ends just after a posedge.
    task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        dm_q.push_back(exp);
        dm_rd = 1'b1; dm_addr = a;
        @(posedge clk); #1;
        dm_rd = 1'b0;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        dm_wr = 1'b1; dm_addr = a; dm_w_data = d;
        @(posedge clk); #1;
        dm_wr = 1'b0;
    endtask

    task automatic cpu_rw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] exp);
        dm_q.push_back(exp);
        dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = a; dm_w_data = d;
        @(posedge clk); #1;
        dm_rd = 1'b0; dm_wr = 1'b0;
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] exp);
        host_exp_t e;
        int n;
        e.is_wr = we; e.data = exp;
        host_q.push_back(e);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!host_ack && n < 50);
        host_req = 1'b0;
        check("host_ack_seen", 32'(host_ack), 32'h1);
    endtask

    // Stimulus helpers for instance 2.
    task automatic cpu2_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        dm_wr2 = 1'b1; dm_addr2 = a; dm_w_data2 = d;
        @(posedge clk); #1;
        dm_wr2 = 1'b0;
    endtask

    task automatic cpu2_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        dm_rd2 = 1'b1; dm_addr2 = a;
        @(posedge clk); #1;
        dm_rd2 = 1'b0;
        check(name, 32'(dm_r_data2), 32'(exp));
    endtask

    // Count sampled cycles with init_done low after a reset release.
    task automatic wait_init(input logic which, output int zeros);
        zeros = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((which == 1'b0) ? init_done : init_done2) break;
            zeros++;
        end
    endtask

    initial begin
        int zeros;
        int a0;

        rst = 1'b1; dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_w_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        rst2 = 1'b1; dm_rd2 = 1'b0; dm_wr2 = 1'b0; dm_addr2 = '0; dm_w_data2 = '0;
        host_req2 = 1'b0; host_we2 = 1'b0; host_addr2 = '0; host_wdata2 = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dm_r_data",    32'(dm_r_data),    32'h0);
        check("rst_host_rdata",   32'(host_rdata),   32'h0);
        check("rst_host_ack",     32'(host_ack),     32'h0);
        check("rst_init_done",    32'(init_done),    32'h0);
        check("rst_err_conflict", 32'(err_conflict), 32'h0);
        check("rst_err_oob",      32'(err_oob),      32'h0);

        // Clear sweep length
        @(posedge clk); #1;
        rst = 1'b0;
        wait_init(1'b0, zeros);
        check("init_cycles", 32'(zeros), 32'd256);
        @(posedge clk); #1;

        // Cleared memory as seen by the host
        host_access(1'b0, 8'd0,   16'h0, 16'h0000);
        host_access(1'b0, 8'd128, 16'h0, 16'h0000);
        host_access(1'b0, 8'd255, 16'h0, 16'h0000);

        // Host write then processor read
        host_access(1'b1, 8'd3, 16'h00A0, 16'h0);
        cpu_read(8'd3, 16'h00A0);

        // Processor write then host read with a single ack pulse
        a0 = ack_cnt;
        cpu_write(8'd4, 16'hFFF6);
        host_access(1'b0, 8'd4, 16'h0, 16'hFFF6);
        repeat (3) begin @(posedge clk); #1; end
        check("single_ack_pulse", 32'(ack_cnt - a0), 32'd1);

        // Read-after-write on consecutive edges, then read data holds
        cpu_write(8'd6, 16'h1234);
        cpu_read(8'd6, 16'h1234);
        repeat (2) begin @(posedge clk); #1; end
        check("dm_r_data_hold", 32'(dm_r_data), 32'h1234);

        // Host request blocked by three back-to-back processor reads
        begin
            host_exp_t e;
            e.is_wr = 1'b0; e.data = 16'hFFF6;
            host_q.push_back(e);
            a0 = ack_cnt;
            host_req = 1'b1; host_we = 1'b0; host_addr = 8'd4;
            dm_rd = 1'b1; dm_addr = 8'd3;
            for (int i = 0; i < 3; i++) begin
                dm_q.push_back(16'h00A0);
                @(posedge clk); #1;
                check("ack_blocked", 32'(host_ack), 32'h0);
            end
            dm_rd = 1'b0;
            @(posedge clk); #1;
            check("ack_after_idle", 32'(host_ack), 32'h1);
            host_req = 1'b0;
            @(posedge clk); #1;
            check("ack_drop", 32'(host_ack), 32'h0);
            check("ack_count_blocked", 32'(ack_cnt - a0), 32'd1);
        end

        // Simultaneous read and write to the same address
        cpu_write(8'd5, 16'h1111);
        cpu_rw(8'd5, 16'h2222, CONFLICT_EXP);
        cpu_read(8'd5, 16'h2222);
        check("err_conflict_set", 32'(err_conflict), 32'h1);
        check("err_oob_clear",    32'(err_oob),      32'h0);
        repeat (3) begin @(posedge clk); #1; end
        check("err_conflict_sticky", 32'(err_conflict), 32'h1);
        check("dm_queue_empty",   32'(dm_q.size()),   32'h0);
        check("host_queue_empty", 32'(host_q.size()), 32'h0);

        // Instance 2: reset during the sweep restarts it
        rst2 = 1'b0;
        repeat (50) begin @(posedge clk); #1; end
        check("init2_mid", 32'(init_done2), 32'h0);
        rst2 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst2 = 1'b0;
        wait_init(1'b1, zeros);
        check("init2_cycles", 32'(zeros), 32'd200);
        @(posedge clk); #1;

        // Instance 2: in-range boundary and out-of-range accesses
        cpu2_write(8'd10, 16'hBEEF);
        cpu2_read("dm2_in_range", 8'd10, 16'hBEEF);
        check("err_oob2_clear", 32'(err_oob2), 32'h0);
        cpu2_write(8'd199, 16'h7777);
        cpu2_read("dm2_last_word", 8'd199, 16'h7777);
        check("err_oob2_edge", 32'(err_oob2), 32'h0);
        cpu2_write(8'd210, 16'h5555);
        cpu2_read("dm2_oob_read", 8'd210, 16'h0000);
        check("err_oob2_set", 32'(err_oob2), 32'h1);
        cpu2_read("dm2_after_oob", 8'd199, 16'h7777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
